// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter in front of a small register bank: grants one requester per
// access, performs the read or write, then returns a one-cycle ack (and read data).
module reg_bank_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*WIDTH-1:0]  wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [WIDTH-1:0]          rdata,
  output logic                      rvalid,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

  state_t               state_reg, state_next;
  logic [PTR_W-1:0]     ptr_reg, ptr_next;
  logic [PTR_W-1:0]     win_reg, win_next;
  logic                 we_lat_reg, we_lat_next;
  logic [ADDR_W-1:0]    addr_lat_reg, addr_lat_next;
  logic [WIDTH-1:0]     wdata_lat_reg, wdata_lat_next;
  logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
  logic [NUM_REQ-1:0]   ack_reg, ack_next;
  logic [WIDTH-1:0]     rdata_reg, rdata_next;
  logic                 rvalid_reg, rvalid_next;
  logic                 busy_reg, busy_next;
  logic                 bank_we;
  logic [WIDTH-1:0]     bank_reg [DEPTH];

  logic [ADDR_W-1:0]    req_addr  [NUM_REQ];
  logic [WIDTH-1:0]     req_wdata [NUM_REQ];
  logic [PTR_W-1:0]     cand;
  logic [PTR_W-1:0]     idx;
  logic                 found;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_addr[gi]  = addr[gi*ADDR_W +: ADDR_W];
      assign req_wdata[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // First pending requester at or after ptr, wrapping around.
  always_comb begin
    cand  = ptr_reg;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr_reg) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        cand  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    win_next       = win_reg;
    we_lat_next    = we_lat_reg;
    addr_lat_next  = addr_lat_reg;
    wdata_lat_next = wdata_lat_reg;
    gnt_next       = gnt_reg;
    ack_next       = '0;
    rdata_next     = rdata_reg;
    rvalid_next    = 1'b0;
    busy_next      = busy_reg;
    bank_we        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          win_next       = cand;
          we_lat_next    = we[cand];
          addr_lat_next  = req_addr[cand];
          wdata_lat_next = req_wdata[cand];
          gnt_next       = NUM_REQ'(1) << cand;
          busy_next      = 1'b1;
          state_next     = XFER;
        end
      end
      XFER: begin
        if (we_lat_reg) begin
          bank_we = 1'b1;
        end else begin
          rdata_next  = bank_reg[addr_lat_reg];
          rvalid_next = 1'b1;
        end
        ack_next   = NUM_REQ'(1) << win_reg;
        state_next = ACK;
      end
      ACK: begin
        gnt_next   = '0;
        busy_next  = 1'b0;
        ptr_next   = (win_reg == PTR_W'(NUM_REQ - 1)) ? '0 : win_reg + 1'b1;
        state_next = IDLE;
      end
      default: begin
        gnt_next   = '0;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      win_reg       <= '0;
      we_lat_reg    <= 1'b0;
      addr_lat_reg  <= '0;
      wdata_lat_reg <= '0;
      gnt_reg       <= '0;
      ack_reg       <= '0;
      rdata_reg     <= '0;
      rvalid_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      for (int k = 0; k < DEPTH; k++) bank_reg[k] <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      win_reg       <= win_next;
      we_lat_reg    <= we_lat_next;
      addr_lat_reg  <= addr_lat_next;
      wdata_lat_reg <= wdata_lat_next;
      gnt_reg       <= gnt_next;
      ack_reg       <= ack_next;
      rdata_reg     <= rdata_next;
      rvalid_reg    <= rvalid_next;
      busy_reg      <= busy_next;
      if (bank_we) bank_reg[addr_lat_reg] <= wdata_lat_reg;
    end
  end

  assign gnt    = gnt_reg;
  assign ack    = ack_reg;
  assign rdata  = rdata_reg;
  assign rvalid = rvalid_reg;
  assign busy   = busy_reg;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: grant order, latency, bank contents and reset abort.
module tb_reg_bank_arbiter;

  localparam int WIDTH   = 16;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*WIDTH-1:0]  wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        ack;
  logic [WIDTH-1:0]          rdata;
  logic                      rvalid;
  logic                      busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  reg_bank_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .rvalid(rvalid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input int i, input logic w, input logic [ADDR_W-1:0] a,
                      input logic [WIDTH-1:0] d);
    req[i]                = 1'b1;
    we[i]                 = w;
    addr[i*ADDR_W +: ADDR_W] = a;
    wdata[i*WIDTH +: WIDTH]  = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    post(0, 1'b0, 2'd2, 16'h0000);
    for (int c = 0; c < 2; c++) begin
      tick();
      vec_cnt++;
      if (gnt !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0 || rvalid !== 1'b0 || rdata !== 16'h0000) begin
        err_cnt++;
        $display("FAIL reset_outputs cyc%0d: gnt=%b ack=%b busy=%b rvalid=%b rdata=%h, want all zero",
                 c, gnt, ack, busy, rvalid, rdata);
      end
    end
    reset = 1'b1;
    tick();
    req = '0;
    vec_cnt++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL rst_rd_grant: gnt=%b busy=%b, want 0001 1", gnt, busy);
    end
    tick();
    vec_cnt++;
    if (ack !== 4'b0001 || rvalid !== 1'b1 || rdata !== 16'h0000) begin
      err_cnt++;
      $display("FAIL rst_rd_data: ack=%b rvalid=%b rdata=%h, want 0001 1 0000", ack, rvalid, rdata);
    end
    tick();
    vec_cnt++;
    if (gnt !== 4'b0000 || ack !== 4'b0000 || rvalid !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_rd_done: gnt=%b ack=%b rvalid=%b busy=%b, want 0000 0000 0 0", gnt, ack, rvalid, busy);
    end
  endtask

  task automatic test_write_read();
    post(0, 1'b1, 2'd1, 16'hBEEF);
    tick();
    req = '0;
    vec_cnt++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || ack !== 4'b0000) begin
      err_cnt++;
      $display("FAIL wr_grant: gnt=%b busy=%b ack=%b, want 0001 1 0000", gnt, busy, ack);
    end
    tick();
    vec_cnt++;
    if (gnt !== 4'b0001 || ack !== 4'b0001 || rvalid !== 1'b0 || rdata !== 16'h0000) begin
      err_cnt++;
      $display("FAIL wr_ack: gnt=%b ack=%b rvalid=%b rdata=%h, want 0001 0001 0 0000", gnt, ack, rvalid, rdata);
    end
    tick();
    vec_cnt++;
    if (gnt !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL wr_done: gnt=%b ack=%b busy=%b, want 0000 0000 0", gnt, ack, busy);
    end
    post(0, 1'b0, 2'd1, 16'h0000);
    tick();
    req = '0;
    tick();
    vec_cnt++;
    if (ack !== 4'b0001 || rvalid !== 1'b1 || rdata !== 16'hBEEF) begin
      err_cnt++;
      $display("FAIL raw_read: ack=%b rvalid=%b rdata=%h, want 0001 1 beef", ack, rvalid, rdata);
    end
    tick();
    vec_cnt++;
    if (rvalid !== 1'b0 || rdata !== 16'hBEEF) begin
      err_cnt++;
      $display("FAIL rdata_hold: rvalid=%b rdata=%h, want 0 beef", rvalid, rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] exp_g;
    reset = 1'b0;
    tick();
    for (int i = 0; i < NUM_REQ; i++) post(i, 1'b0, ADDR_W'(i), 16'h0000);
    reset = 1'b1;
    for (int g = 0; g < 5; g++) begin
      exp_g = NUM_REQ'(1) << (g % NUM_REQ);
      tick();
      if (g == 4) req = '0;
      vec_cnt++;
      if (gnt !== exp_g || busy !== 1'b1) begin
        err_cnt++;
        $display("FAIL rr_grant%0d: gnt=%b busy=%b, want %b 1", g, gnt, busy, exp_g);
      end
      tick();
      vec_cnt++;
      if (gnt !== exp_g || ack !== exp_g) begin
        err_cnt++;
        $display("FAIL rr_ack%0d: gnt=%b ack=%b, want %b %b", g, gnt, ack, exp_g, exp_g);
      end
      tick();
      vec_cnt++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
        err_cnt++;
        $display("FAIL rr_gap%0d: gnt=%b busy=%b, want 0000 0", g, gnt, busy);
      end
    end
  endtask

  task automatic test_wrap();
    // ptr is 1 here; a grant to req2 moves it to 3
    post(2, 1'b0, 2'd0, 16'h0000);
    tick();
    req = '0;
    vec_cnt++;
    if (gnt !== 4'b0100) begin
      err_cnt++;
      $display("FAIL wrap_pre: gnt=%b, want 0100", gnt);
    end
    tick();
    tick();
    post(0, 1'b0, 2'd0, 16'h0000);
    post(3, 1'b0, 2'd0, 16'h0000);
    tick();
    req[3] = 1'b0;
    vec_cnt++;
    if (gnt !== 4'b1000) begin
      err_cnt++;
      $display("FAIL wrap_first: gnt=%b, want 1000", gnt);
    end
    tick();
    tick();
    tick();
    req = '0;
    vec_cnt++;
    if (gnt !== 4'b0001) begin
      err_cnt++;
      $display("FAIL wrap_second: gnt=%b, want 0001", gnt);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_abort();
    post(1, 1'b1, 2'd0, 16'h1234);
    tick();
    req = '0;
    vec_cnt++;
    if (gnt !== 4'b0010) begin
      err_cnt++;
      $display("FAIL abort_grant: gnt=%b, want 0010", gnt);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    vec_cnt++;
    if (ack !== 4'b0000 || busy !== 1'b0 || gnt !== 4'b0000) begin
      err_cnt++;
      $display("FAIL abort_state: ack=%b busy=%b gnt=%b, want 0000 0 0000", ack, busy, gnt);
    end
    post(1, 1'b0, 2'd0, 16'h0000);
    tick();
    req = '0;
    tick();
    vec_cnt++;
    if (ack !== 4'b0010 || rvalid !== 1'b1 || rdata !== 16'h0000) begin
      err_cnt++;
      $display("FAIL abort_read: ack=%b rvalid=%b rdata=%h, want 0010 1 0000", ack, rvalid, rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    post(2, 1'b1, 2'd3, 16'hA5A5);
    post(3, 1'b0, 2'd3, 16'h0000);
    tick();
    req[2] = 1'b0;
    vec_cnt++;
    if (gnt !== 4'b0100) begin
      err_cnt++;
      $display("FAIL b2b_first: gnt=%b, want 0100", gnt);
    end
    tick();
    vec_cnt++;
    if (ack !== 4'b0100 || rvalid !== 1'b0 || rdata !== 16'h0000) begin
      err_cnt++;
      $display("FAIL b2b_wr_ack: ack=%b rvalid=%b rdata=%h, want 0100 0 0000", ack, rvalid, rdata);
    end
    tick();
    tick();
    req = '0;
    vec_cnt++;
    if (gnt !== 4'b1000) begin
      err_cnt++;
      $display("FAIL b2b_second: gnt=%b, want 1000", gnt);
    end
    tick();
    vec_cnt++;
    if (ack !== 4'b1000 || rvalid !== 1'b1 || rdata !== 16'hA5A5) begin
      err_cnt++;
      $display("FAIL b2b_read: ack=%b rvalid=%b rdata=%h, want 1000 1 a5a5", ack, rvalid, rdata);
    end
    tick();
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_wrap();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
